// File: rtl/card_datapath.sv
// Baccarat card/score datapath with a two-state wager FSM and a saturating bankroll.
// Cards are drawn from a free-running 1..13 counter; scores are combinational from the card registers.
module card_datapath (
  input  logic       clock,
  input  logic       resetb,
  input  logic       load_pcard1,
  input  logic       load_pcard2,
  input  logic       load_pcard3,
  input  logic       load_dcard1,
  input  logic       load_dcard2,
  input  logic       load_dcard3,
  input  logic       clear_hand,
  input  logic       player_win_light,
  input  logic       dealer_win_light,
  input  logic [7:0] bet_amount,
  input  logic [1:0] bet_side,
  input  logic       place_bet,
  input  logic       settle,
  output logic [3:0] pcard1,
  output logic [3:0] pcard2,
  output logic [3:0] pcard3_rank,
  output logic [3:0] dcard1,
  output logic [3:0] dcard2,
  output logic [3:0] dcard3,
  output logic [3:0] pscore,
  output logic [3:0] dscore,
  output logic [3:0] pcard3,
  output logic [7:0] balance,
  output logic       betenabled,
  output logic [7:0] bet_held
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_HELD = 1'b1} state_t;

  logic [3:0] r_counter;
  logic [3:0] r_pcard1, r_pcard2, r_pcard3, r_dcard1, r_dcard2, r_dcard3;
  logic       r_place_prev, r_settle_prev;
  logic [7:0] r_balance, r_bet_held;
  logic [1:0] r_side;
  state_t     r_state, w_state_nxt;

  logic       w_place_edge, w_settle_edge;
  logic       w_do_latch, w_do_settle;
  logic [1:0] w_lights;
  logic [11:0] w_sum;
  logic [7:0] w_balance_nxt, w_bet_capped;

  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank >= 4'd1 && rank <= 4'd9) ? rank : 4'd0;
  endfunction

  function automatic logic [3:0] mod10(input logic [4:0] s);
    logic [4:0] r;
    if (s >= 5'd20)      r = s - 5'd20;
    else if (s >= 5'd10) r = s - 5'd10;
    else                 r = s;
    return r[3:0];
  endfunction

  function automatic logic [7:0] sat255(input logic [11:0] v);
    return (v > 12'd255) ? 8'd255 : v[7:0];
  endfunction

  function automatic logic [3:0] hand_score(input logic [3:0] a, input logic [3:0] b,
                                            input logic [3:0] c);
    return mod10({1'b0, card_value(a)} + {1'b0, card_value(b)} + {1'b0, card_value(c)});
  endfunction

  // Card source and hand registers
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_counter <= 4'd1;
      r_pcard1  <= 4'd0;
      r_pcard2  <= 4'd0;
      r_pcard3  <= 4'd0;
      r_dcard1  <= 4'd0;
      r_dcard2  <= 4'd0;
      r_dcard3  <= 4'd0;
    end else begin
      r_counter <= (r_counter == 4'd13) ? 4'd1 : r_counter + 4'd1;
      if (clear_hand) begin
        r_pcard1 <= 4'd0;
        r_pcard2 <= 4'd0;
        r_pcard3 <= 4'd0;
        r_dcard1 <= 4'd0;
        r_dcard2 <= 4'd0;
        r_dcard3 <= 4'd0;
      end else begin
        if (load_pcard1) r_pcard1 <= r_counter;
        if (load_pcard2) r_pcard2 <= r_counter;
        if (load_pcard3) r_pcard3 <= r_counter;
        if (load_dcard1) r_dcard1 <= r_counter;
        if (load_dcard2) r_dcard2 <= r_counter;
        if (load_dcard3) r_dcard3 <= r_counter;
      end
    end
  end

  assign pcard1      = r_pcard1;
  assign pcard2      = r_pcard2;
  assign pcard3_rank = r_pcard3;
  assign dcard1      = r_dcard1;
  assign dcard2      = r_dcard2;
  assign dcard3      = r_dcard3;
  assign pcard3      = card_value(r_pcard3);
  assign pscore      = hand_score(r_pcard1, r_pcard2, r_pcard3);
  assign dscore      = hand_score(r_dcard1, r_dcard2, r_dcard3);

  // Edge detection of the wager controls
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_place_prev  <= 1'b0;
      r_settle_prev <= 1'b0;
    end else begin
      r_place_prev  <= place_bet;
      r_settle_prev <= settle;
    end
  end

  assign w_place_edge  = place_bet & ~r_place_prev;
  assign w_settle_edge = settle & ~r_settle_prev;

  // Wager FSM: state register, next state, outputs
  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_place_edge && bet_side != 2'b00) w_state_nxt = S_HELD;
      S_HELD:  if (w_settle_edge) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    betenabled  = (r_state == S_IDLE);
    w_do_latch  = (r_state == S_IDLE) && w_place_edge && (bet_side != 2'b00);
    w_do_settle = (r_state == S_HELD) && w_settle_edge;
  end

  // Settlement outcome; a tie bet pays eight to one
  assign w_lights     = {player_win_light, dealer_win_light};
  assign w_sum        = {4'd0, r_balance} +
                        ((r_side == 2'b11) ? {1'b0, r_bet_held, 3'b000} : {4'd0, r_bet_held});
  assign w_bet_capped = (bet_amount > r_balance) ? r_balance : bet_amount;

  always_comb begin
    w_balance_nxt = r_balance;
    case (w_lights)
      2'b10, 2'b01: begin
        if ((w_lights == 2'b10 && r_side == 2'b01) || (w_lights == 2'b01 && r_side == 2'b10))
          w_balance_nxt = sat255(w_sum);
        else
          w_balance_nxt = (r_balance >= r_bet_held) ? r_balance - r_bet_held : 8'd0;
      end
      2'b11: begin
        if (r_side == 2'b11) w_balance_nxt = sat255(w_sum);
      end
      default: w_balance_nxt = r_balance;
    endcase
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      r_balance  <= 8'd100;
      r_bet_held <= 8'd0;
      r_side     <= 2'b00;
    end else if (w_do_latch) begin
      r_bet_held <= w_bet_capped;
      r_side     <= bet_side;
    end else if (w_do_settle) begin
      r_balance  <= w_balance_nxt;
      r_bet_held <= 8'd0;
    end
  end

  assign balance  = r_balance;
  assign bet_held = r_bet_held;

endmodule

// File: tb/tb_card_datapath.sv
// Directed bench for card_datapath: expected values go into a scoreboard queue as stimulus is
// applied and are popped and compared against the DUT outputs sampled on the falling edge.
module tb_card_datapath;

  logic       clock;
  logic       resetb;
  logic [5:0] ld;
  logic       clear_hand;
  logic       player_win_light, dealer_win_light;
  logic [7:0] bet_amount;
  logic [1:0] bet_side;
  logic       place_bet, settle;
  logic [3:0] pcard1, pcard2, pcard3_rank, dcard1, dcard2, dcard3;
  logic [3:0] pscore, dscore, pcard3;
  logic [7:0] balance, bet_held;
  logic       betenabled;

  int checks = 0;
  int failures = 0;
  int cnt = 1;
  logic [11:0] exp_q[$];

  card_datapath dut (
    .clock(clock), .resetb(resetb),
    .load_pcard1(ld[0]), .load_pcard2(ld[1]), .load_pcard3(ld[2]),
    .load_dcard1(ld[3]), .load_dcard2(ld[4]), .load_dcard3(ld[5]),
    .clear_hand(clear_hand),
    .player_win_light(player_win_light), .dealer_win_light(dealer_win_light),
    .bet_amount(bet_amount), .bet_side(bet_side),
    .place_bet(place_bet), .settle(settle),
    .pcard1(pcard1), .pcard2(pcard2), .pcard3_rank(pcard3_rank),
    .dcard1(dcard1), .dcard2(dcard2), .dcard3(dcard3),
    .pscore(pscore), .dscore(dscore), .pcard3(pcard3),
    .balance(balance), .betenabled(betenabled), .bet_held(bet_held)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic push(input int v);
    exp_q.push_back(12'(v));
  endtask

  task automatic chk(input string tag, input logic [11:0] obs);
    logic [11:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL %s scoreboard empty observed=%0d", tag, obs);
    end else begin
      e = exp_q.pop_front();
      assert (obs === e) else begin
        failures++;
        $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cnt = (cnt == 13) ? 1 : cnt + 1;
    @(negedge clock);
  endtask

  task automatic load_multi(input logic [5:0] mask, input int rank);
    int guard = 0;
    while (cnt != rank && guard < 20) begin
      tick();
      guard++;
    end
    ld = mask;
    tick();
    ld = 6'b0;
  endtask

  task automatic place(input int amt, input logic [1:0] side);
    bet_amount = 8'(amt);
    bet_side   = side;
    place_bet  = 1'b1;
    tick();
    place_bet  = 1'b0;
    tick();
  endtask

  task automatic do_settle(input logic [1:0] lights);
    {player_win_light, dealer_win_light} = lights;
    settle = 1'b1;
    tick();
    settle = 1'b0;
    tick();
  endtask

  initial begin
    resetb = 1'b0; ld = 6'b0; clear_hand = 1'b0;
    player_win_light = 1'b0; dealer_win_light = 1'b0;
    bet_amount = 8'd0; bet_side = 2'b00; place_bet = 1'b0; settle = 1'b0;
    repeat (2) @(negedge clock);

    push(0);   chk("rst_pcard1", 12'(pcard1));
    push(0);   chk("rst_pscore", 12'(pscore));
    push(0);   chk("rst_dscore", 12'(dscore));
    push(1);   chk("rst_betenabled", 12'(betenabled));
    push(100); chk("rst_balance", 12'(balance));
    push(0);   chk("rst_bet_held", 12'(bet_held));

    resetb = 1'b1;
    cnt = 1;
    ld[0] = 1'b1; tick(); ld = 6'b0;
    ld[3] = 1'b1; tick(); ld = 6'b0;
    push(1); chk("first_pcard1", 12'(pcard1));
    push(2); chk("first_dcard1", 12'(dcard1));
    push(1); chk("first_pscore", 12'(pscore));
    push(2); chk("first_dscore", 12'(dscore));

    clear_hand = 1'b1; tick(); clear_hand = 1'b0;
    load_multi(6'b000001, 7);
    load_multi(6'b000010, 13);
    load_multi(6'b001000, 9);
    load_multi(6'b010000, 5);
    push(7); chk("hand_pscore", 12'(pscore));
    push(4); chk("hand_dscore", 12'(dscore));
    load_multi(6'b000100, 12);
    push(12); chk("p3_rank_q", 12'(pcard3_rank));
    push(0);  chk("p3_value_q", 12'(pcard3));
    push(7);  chk("p3_pscore", 12'(pscore));
    load_multi(6'b100100, 3);
    push(3); chk("multi_pcard3", 12'(pcard3));
    push(3); chk("multi_dcard3", 12'(dcard3));
    push(0); chk("multi_pscore", 12'(pscore));
    push(7); chk("multi_dscore", 12'(dscore));

    clear_hand = 1'b1; ld[1] = 1'b1; tick(); clear_hand = 1'b0; ld = 6'b0;
    push(0); chk("clr_cards", 12'({pcard1, pcard2, pcard3_rank}));
    push(0); chk("clr_dcards", 12'({dcard1, dcard2, dcard3}));
    push(0); chk("clr_scores", 12'({pscore, dscore}));

    place(30, 2'b01);
    push(30); chk("bet30_held", 12'(bet_held));
    push(0);  chk("bet30_enabled", 12'(betenabled));
    do_settle(2'b10);
    push(130); chk("win_balance", 12'(balance));
    push(1);   chk("win_enabled", 12'(betenabled));
    push(0);   chk("win_bet_held", 12'(bet_held));

    place(110, 2'b10);
    do_settle(2'b10);
    push(20); chk("lose_balance", 12'(balance));
    place(50, 2'b10);
    push(20); chk("cap_bet_held", 12'(bet_held));
    do_settle(2'b10);
    push(0); chk("floor_balance", 12'(balance));

    place(10, 2'b00);
    push(1); chk("side00_ignored", 12'(betenabled));

    place(5, 2'b01);
    push(0); chk("held_zero_bet", 12'(betenabled));
    @(negedge clock); #2 resetb = 1'b0; #1;
    push(100); chk("midheld_rst_balance", 12'(balance));
    push(1);   chk("midheld_rst_enabled", 12'(betenabled));
    push(0);   chk("midheld_rst_held", 12'(bet_held));
    @(negedge clock); resetb = 1'b1; cnt = 1;

    place(60, 2'b01);
    do_settle(2'b01);
    push(40); chk("bal40", 12'(balance));

    place(30, 2'b11);
    {player_win_light, dealer_win_light} = 2'b11;
    settle = 1'b1; tick();
    push(255); chk("tie_sat_balance", 12'(balance));
    push(1);   chk("tie_enabled", 12'(betenabled));
    bet_amount = 8'd10; bet_side = 2'b01; place_bet = 1'b1; tick(); place_bet = 1'b0;
    push(10); chk("rebet_held", 12'(bet_held));
    repeat (3) tick();
    push(0);   chk("settle_level_once_en", 12'(betenabled));
    push(255); chk("settle_level_once_bal", 12'(balance));
    push(10);  chk("settle_level_once_held", 12'(bet_held));
    settle = 1'b0; tick();

    {player_win_light, dealer_win_light} = 2'b01;
    bet_amount = 8'd99; bet_side = 2'b10;
    place_bet = 1'b1; settle = 1'b1; tick(); place_bet = 1'b0; settle = 1'b0; tick();
    push(245); chk("simul_held_balance", 12'(balance));
    push(1);   chk("simul_held_enabled", 12'(betenabled));

    bet_amount = 8'd5; bet_side = 2'b01;
    place_bet = 1'b1; settle = 1'b1; tick(); place_bet = 1'b0; settle = 1'b0; tick();
    push(0);   chk("simul_idle_enabled", 12'(betenabled));
    push(5);   chk("simul_idle_held", 12'(bet_held));
    push(245); chk("simul_idle_balance", 12'(balance));

    do_settle(2'b11);
    push(245); chk("push_balance", 12'(balance));
    place(7, 2'b10);
    do_settle(2'b00);
    push(245); chk("lights00_balance", 12'(balance));
    push(1);   chk("lights00_enabled", 12'(betenabled));
    place(45, 2'b11);
    do_settle(2'b10);
    push(200); chk("tie_lose_balance", 12'(balance));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
